data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port reg_wr_en, input, 1 bit: register-file write enable.
REQ-004 SHALL have port operands, input, 12 bits: instruction operand field.
REQ-005 SHALL have port alu_cmd, input, alu::AluCmd: ALU operation select.
REQ-006 SHALL have port ctrl_sig, input, ctrl::CtrlSig: control bundle; field dst_in_sel selects the write-data source.
REQ-007 SHALL have port alu_out, output, 8 bits: combinational ALU result.
REQ-008 SHALL have port flag_z, output, 1 bit: registered zero flag.
REQ-009 SHALL have port flag_c, output, 1 bit: registered carry/borrow flag.

Function
REQ-010 SHALL contain 16 registers r0..r15, 8 bits each, all writable; r0 is not hardwired.
REQ-011 SHALL decode operands as dst=[11:8], src_a=[7:4], src_b=[3:0], imm=[7:0].
REQ-012 SHALL read r[src_a] and r[src_b] combinationally into ALU inputs A and B.
REQ-013 SHALL select write data = imm when dst_in_sel=1, alu_out when dst_in_sel=0.
REQ-014 SHALL write the write data to r[dst] on the rising clk edge when reg_wr_en=1 and rst_n=1; no register changes otherwise.
REQ-015 SHALL return the pre-edge value when dst equals src_a or src_b; the new value is visible after the edge.
REQ-016 SHALL implement ADD = A+B and SUB = A-B mod 256; carry = bit 8 of the sum for ADD, borrow (A<B) for SUB.
REQ-017 SHALL implement AND, OR, XOR, NOT (~A), and PASS_A (A), each with carry=0.
REQ-018 SHALL implement SHL (A<<1, carry=A[7]) and SHR (logical A>>1, carry=A[0]).
REQ-019 SHALL output result 0 and carry 0 for any unused AluCmd encoding.
REQ-020 SHALL update flag_z (result==0) and flag_c on the edge only when reg_wr_en=1 and dst_in_sel=0; flags SHALL hold otherwise, including during immediate loads.
REQ-021 SHALL produce alu_out with zero-cycle latency; a write completes in one cycle.

Reset
REQ-022 SHALL clear all 16 registers, flag_z and flag_c to 0 on a rising clk edge with rst_n=0.
REQ-023 SHALL give reset priority over a simultaneous write.
REQ-024 SHALL have alu_out follow reset register contents combinationally, so it equals 0 for ADD after reset.

Configuration
REQ-025 SHALL, when DATAPATH_DBG_PORT_EN is defined, add input dbg_addr[3:0] and output dbg_data[7:0] = r[dbg_addr], combinational.
REQ-026 SHALL, when DATAPATH_DBG_PORT_EN is not defined, omit both debug ports, with all other behaviour unchanged.

Structure
REQ-027 SHALL take AluCmd from package alu as a 4-bit enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7, PASS_A=8.
REQ-028 SHALL take CtrlSig from package ctrl as a packed struct containing at least dst_in_sel.
REQ-029 SHALL place the ALU combinational logic in one sub-module named alu_unit (inputs A, B, cmd; outputs result, carry, zero); the register file stays in data_path.

Verification
REQ-030 SHALL verify immediate load and ADD: reg_wr_en=1, dst_in_sel=1, operands {1,20} then {3,10}; then dst_in_sel=0, ADD, operands {5,1,3} -> r1=20, r3=10, r5=30, flag_z=0, flag_c=0.
REQ-031 SHALL verify SUB with borrow: r3=10, r1=20, SUB, operands {6,3,1} -> r6=246, flag_c=1, flag_z=0.
REQ-032 SHALL verify zero and carry on ADD: r2=200, r4=56, ADD into r7 -> r7=0, flag_z=1, flag_c=1.
REQ-033 SHALL verify write disable: reg_wr_en=0 with operands {1,99} for 3 cycles -> r1 unchanged, flags unchanged.
REQ-034 SHALL verify reset with a simultaneous write: rst_n=0 with reg_wr_en=1 writing {5,77} -> all registers 0 and flags 0 after the edge.
REQ-035 SHALL verify shift and self-overwrite: r8=0x81, SHL with operands {8,8,0} -> r8=0x02, flag_c=1; alu_out shows 0x02 before the edge.

Source files
------------

// File: rtl/data_path_pkg.sv
// Shared types for the data path: ALU command encoding (package alu) and the
// control bundle (package ctrl).
package alu;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [3:0] {
    ADD    = 4'd0,
    SUB    = 4'd1,
    AND    = 4'd2,
    OR     = 4'd3,
    XOR    = 4'd4,
    NOT    = 4'd5,
    SHL    = 4'd6,
    SHR    = 4'd7,
    PASS_A = 4'd8
  } AluCmd;
endpackage

package ctrl;
  typedef struct packed {
    logic dst_in_sel;
  } CtrlSig;
endpackage

// File: rtl/data_path_alu_unit.sv
// Combinational 8-bit ALU; unused command encodings yield result 0, carry 0.
module alu_unit
  import alu::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  AluCmd             cmd,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);
  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  // Bit 8 of the extended difference is the borrow (a < b).
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (cmd)
      ADD:    begin result = sum_ext[DATA_W-1:0];  carry = sum_ext[DATA_W];  end
      SUB:    begin result = diff_ext[DATA_W-1:0]; carry = diff_ext[DATA_W]; end
      AND:    result = a & b;
      OR:     result = a | b;
      XOR:    result = a ^ b;
      NOT:    result = ~a;
      SHL:    begin result = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; end
      SHR:    begin result = {1'b0, a[DATA_W-1:1]}; carry = a[0];        end
      PASS_A: result = a;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/data_path.sv
// 16x8 register file feeding an ALU, with registered zero/carry flags.
// Optional debug read port enabled by defining DATAPATH_DBG_PORT_EN.
module data_path
  import alu::*;
  import ctrl::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_wr_en,
  input  logic [11:0]       operands,
  input  AluCmd             alu_cmd,
  input  CtrlSig            ctrl_sig,
`ifdef DATAPATH_DBG_PORT_EN
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
`endif
  output logic [DATA_W-1:0] alu_out,
  output logic              flag_z,
  output logic              flag_c
);
  localparam int unsigned NUM_REGS = 16;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [3:0]        dst;
  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] wr_data;
  logic              alu_carry;
  logic              alu_zero;

  assign dst   = operands[11:8];
  assign src_a = operands[7:4];
  assign src_b = operands[3:0];
  assign imm   = operands[7:0];

  alu_unit u_alu (
    .a      (regs[src_a]),
    .b      (regs[src_b]),
    .cmd    (alu_cmd),
    .result (alu_out),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  assign wr_data = ctrl_sig.dst_in_sel ? imm : alu_out;

  // Reads see pre-edge contents, so dst == src_a/src_b reads the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_wr_en) begin
      regs[dst] <= wr_data;
    end
  end

  // Flags track ALU writes only; immediate loads leave them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (reg_wr_en && !ctrl_sig.dst_in_sel) begin
      flag_z <= alu_zero;
      flag_c <= alu_carry;
    end
  end

`ifdef DATAPATH_DBG_PORT_EN
  assign dbg_data = regs[dbg_addr];
`endif
endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: a behavioural model predicts alu_out each
// cycle and the flags after each edge; directed scenarios add fixed checks.
module tb_data_path;
  import alu::*;
  import ctrl::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reg_wr_en;
  logic [11:0] operands;
  AluCmd      alu_cmd;
  CtrlSig     ctrl_sig;
  logic [7:0] alu_out;
  logic       flag_z;
  logic       flag_c;
`ifdef DATAPATH_DBG_PORT_EN
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;
`endif

  data_path dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_wr_en (reg_wr_en),
    .operands  (operands),
    .alu_cmd   (alu_cmd),
    .ctrl_sig  (ctrl_sig),
`ifdef DATAPATH_DBG_PORT_EN
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
`endif
    .alu_out   (alu_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] m_regs [16];
  logic       m_z = 1'b0;
  logic       m_c = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU written with integer arithmetic.
  task automatic model_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                           output logic [7:0] res, output logic c);
    int ia, ib, t;
    ia = int'(a);
    ib = int'(b);
    res = 8'd0;
    c = 1'b0;
    case (cmd)
      4'd0: begin t = ia + ib; res = 8'(t % 256); c = (t > 255); end
      4'd1: begin t = ia - ib + 256; res = 8'(t % 256); c = (ia < ib); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = 8'(255 - ia);
      4'd6: begin res = 8'((ia * 2) % 256); c = (ia >= 128); end
      4'd7: begin res = 8'(ia / 2); c = (ia % 2 == 1); end
      4'd8: res = a;
      default: begin res = 8'd0; c = 1'b0; end
    endcase
  endtask

  task automatic cycle(input logic rst, input logic wr, input logic [11:0] ops,
                       input logic [3:0] cmd, input logic sel);
    logic [7:0] r;
    logic       c;
    exp_t       e;
    @(negedge clk);
    rst_n = rst;
    reg_wr_en = wr;
    operands = ops;
    alu_cmd = AluCmd'(cmd);
    ctrl_sig.dst_in_sel = sel;
    model_alu(m_regs[ops[7:4]], m_regs[ops[3:0]], cmd, r, c);
    sb.push_back('{"alu_out", r});
    #1;
    e = sb.pop_front();
    check(e.tag, alu_out, e.val);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
      m_z = 1'b0;
      m_c = 1'b0;
    end else if (wr) begin
      m_regs[ops[11:8]] = sel ? ops[7:0] : r;
      if (!sel) begin
        m_z = (r == 8'd0);
        m_c = c;
      end
    end
    #1;
    check("flag_z", 8'(flag_z), 8'(m_z));
    check("flag_c", 8'(flag_c), 8'(m_c));
  endtask

  // Read a register through PASS_A without writing and compare to a fixed value.
  task automatic peek(input string tag, input logic [3:0] idx, input logic [7:0] exp);
    cycle(1'b1, 1'b0, {4'h0, idx, 4'h0}, 4'd8, 1'b0);
    check(tag, alu_out, exp);
`ifdef DATAPATH_DBG_PORT_EN
    dbg_addr = idx;
    #1;
    check({tag, "_dbg"}, dbg_data, exp);
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
    rst_n = 1'b0;
    reg_wr_en = 1'b0;
    operands = 12'h0;
    alu_cmd = ADD;
    ctrl_sig.dst_in_sel = 1'b0;
`ifdef DATAPATH_DBG_PORT_EN
    dbg_addr = 4'h0;
`endif
    repeat (2) @(posedge clk);

    cycle(1'b0, 1'b0, 12'h000, 4'd0, 1'b0);
    check("rst_alu_add", alu_out, 8'd0);

    // Immediate loads then ADD
    cycle(1'b1, 1'b1, 12'h114, 4'd0, 1'b1);
    cycle(1'b1, 1'b1, 12'h30A, 4'd0, 1'b1);
    cycle(1'b1, 1'b1, 12'h513, 4'd0, 1'b0);
    check("add_z", 8'(flag_z), 8'd0);
    check("add_c", 8'(flag_c), 8'd0);
    peek("r1", 4'd1, 8'd20);
    peek("r3", 4'd3, 8'd10);
    peek("r5", 4'd5, 8'd30);

    // SUB with borrow
    cycle(1'b1, 1'b1, 12'h631, 4'd1, 1'b0);
    check("sub_c", 8'(flag_c), 8'd1);
    check("sub_z", 8'(flag_z), 8'd0);
    peek("r6", 4'd6, 8'd246);

    // ADD wrapping to zero with carry
    cycle(1'b1, 1'b1, 12'h2C8, 4'd0, 1'b1);
    cycle(1'b1, 1'b1, 12'h438, 4'd0, 1'b1);
    check("imm_hold_c", 8'(flag_c), 8'd1);
    cycle(1'b1, 1'b1, 12'h724, 4'd0, 1'b0);
    check("addz_z", 8'(flag_z), 8'd1);
    check("addz_c", 8'(flag_c), 8'd1);
    peek("r7", 4'd7, 8'd0);

    // Write disabled for three cycles
    repeat (3) cycle(1'b1, 1'b0, 12'h163, 4'd0, 1'b1);
    check("wrdis_z", 8'(flag_z), 8'd1);
    check("wrdis_c", 8'(flag_c), 8'd1);
    peek("r1_hold", 4'd1, 8'd20);

    // Shift-left with dst == src_a
    cycle(1'b1, 1'b1, 12'h881, 4'd0, 1'b1);
    cycle(1'b1, 1'b1, 12'h880, 4'd6, 1'b0);
    check("shl_c", 8'(flag_c), 8'd1);
    peek("r8", 4'd8, 8'h02);

    // Reset wins over a simultaneous write
    cycle(1'b0, 1'b1, 12'h54D, 4'd0, 1'b1);
    check("rstw_z", 8'(flag_z), 8'd0);
    check("rstw_c", 8'(flag_c), 8'd0);
    for (int i = 0; i < 16; i++) peek($sformatf("rst_r%0d", i), 4'(i), 8'd0);

    // Random traffic, including unused command encodings
    for (int n = 0; n < 80; n++) begin
      cycle(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) != 0),
            12'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 16; i++) peek($sformatf("end_r%0d", i), 4'(i), m_regs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
